// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius (Simon-style) round controller.
package genius_pkg;

  localparam int unsigned SEQ_LEN = 16;
  localparam int unsigned SEQ_AW  = 4;

  // x^8 + x^6 + x^5 + x^4 + 1 taps bits 7,5,4,3 of a left-shifting register
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;
  localparam logic [7:0] LFSR_RESET = 8'h01;

  localparam int unsigned DEF_SHOW_T = 8;
  localparam int unsigned DEF_GAP_T  = 4;
  localparam int unsigned DEF_TO_T   = 64;

  typedef logic [1:0] colour_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_INPUT,
    ST_WIN,
    ST_LOSE
  } state_e;

  function automatic logic [3:0] colour_onehot(input colour_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/genius_lfsr.sv
// 8-bit Fibonacci LFSR with seed load and step enable; exposes the colour of the next state.
module genius_lfsr
  import genius_pkg::*;
(
  input  logic       clk_i,
  input  logic       rn_i,
  input  logic       i_load,
  input  logic [7:0] i_seed,
  input  logic       i_step,
  output colour_t    o_colour_c
);

  logic [7:0] r_state;
  logic [7:0] w_next;

  always_comb begin
    w_next = {r_state[6:0], ^(r_state & LFSR_TAPS)};
  end

  assign o_colour_c = w_next[1:0];

  // A zero seed would lock the register at zero, so it is replaced by 8'h01
  always_ff @(posedge clk_i or negedge rn_i) begin
    if (!rn_i) begin
      r_state <= LFSR_RESET;
    end else if (i_load) begin
      r_state <= (i_seed == 8'h00) ? LFSR_RESET : i_seed;
    end else if (i_step) begin
      r_state <= w_next;
    end
  end

endmodule

// File: rtl/genius_round_ctrl.sv
// Round controller: builds a 16-step colour sequence, replays a growing prefix, checks player presses.
module genius_round_ctrl
  import genius_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned SHOW_T = DEF_SHOW_T,
  parameter int unsigned GAP_T  = DEF_GAP_T,
  parameter int unsigned TO_T   = DEF_TO_T
) (
  input  logic         clk_i,
  input  logic         rn_i,
  input  logic         start_i,
  input  logic [7:0]   seed_i,
  input  logic [N-1:0] level_i,
  input  logic [3:0]   btn_i,
  output logic [3:0]   led_o,
  output logic [N-1:0] round_o,
  output logic         busy_o,
  output logic         win_o,
  output logic         lose_o
);

  localparam int unsigned CW = $clog2(TO_T + SHOW_T + GAP_T) + 1;

  state_e            r_state;
  logic [N-1:0]      r_level;
  logic [N-1:0]      r_round;
  logic [N-1:0]      r_idx;
  logic [SEQ_AW-1:0] r_k;
  logic [CW-1:0]     r_cnt;
  logic              r_replay;
  logic [3:0]        r_led;
  logic              r_busy;
  logic              r_win;
  logic              r_lose;
  colour_t           r_seq [SEQ_LEN];

  logic              w_start_ok;
  logic              w_seq_we;
  colour_t           w_lfsr_colour;
  logic [3:0]        w_exp;
  logic [3:0]        w_next_exp;

  assign w_start_ok = start_i &&
                      ((r_state == ST_IDLE) || (r_state == ST_WIN) || (r_state == ST_LOSE));
  assign w_seq_we   = (r_state == ST_LOAD);
  assign w_exp      = colour_onehot(r_seq[SEQ_AW'(r_idx)]);
  assign w_next_exp = colour_onehot(r_seq[SEQ_AW'(r_idx + N'(1))]);

  genius_lfsr u_lfsr (
    .clk_i      (clk_i),
    .rn_i       (rn_i),
    .i_load     (w_start_ok),
    .i_seed     (seed_i),
    .i_step     (w_seq_we),
    .o_colour_c (w_lfsr_colour)
  );

  // Sequence RAM, filled once per game during LOAD
  always_ff @(posedge clk_i) begin
    if (w_seq_we) begin
      r_seq[r_k] <= w_lfsr_colour;
    end
  end

  always_ff @(posedge clk_i or negedge rn_i) begin
    if (!rn_i) begin
      r_state  <= ST_IDLE;
      r_level  <= '0;
      r_round  <= '0;
      r_idx    <= '0;
      r_k      <= '0;
      r_cnt    <= '0;
      r_replay <= 1'b0;
      r_led    <= 4'b0000;
      r_busy   <= 1'b0;
      r_win    <= 1'b0;
      r_lose   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (start_i) begin
            r_state  <= ST_LOAD;
            r_level  <= level_i;
            r_round  <= '0;
            r_idx    <= '0;
            r_k      <= '0;
            r_cnt    <= '0;
            r_replay <= 1'b0;
            r_led    <= 4'b0000;
            r_busy   <= 1'b1;
            r_win    <= 1'b0;
            r_lose   <= 1'b0;
          end
        end

        ST_LOAD: begin
          r_k <= r_k + SEQ_AW'(1);
          if (r_k == SEQ_AW'(SEQ_LEN - 1)) begin
            r_state <= ST_SHOW_ON;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_led   <= colour_onehot(r_seq[0]);
          end
        end

        ST_SHOW_ON: begin
          if (r_cnt == CW'(SHOW_T - 1)) begin
            r_state <= ST_SHOW_OFF;
            r_cnt   <= '0;
            r_led   <= 4'b0000;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        // r_replay marks the gap that precedes a new round, which replays from step 0
        ST_SHOW_OFF: begin
          if (r_cnt == CW'(GAP_T - 1)) begin
            r_cnt <= '0;
            if (r_replay) begin
              r_replay <= 1'b0;
              r_state  <= ST_SHOW_ON;
              r_led    <= w_exp;
            end else if (r_idx == r_round) begin
              r_state <= ST_INPUT;
              r_idx   <= '0;
            end else begin
              r_state <= ST_SHOW_ON;
              r_idx   <= r_idx + N'(1);
              r_led   <= w_next_exp;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_INPUT: begin
          r_led <= 4'b0000;
          if (btn_i == 4'b0000) begin
            if (r_cnt == CW'(TO_T - 1)) begin
              r_state <= ST_LOSE;
              r_busy  <= 1'b0;
              r_lose  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else if (btn_i == w_exp) begin
            r_cnt <= '0;
            if (r_idx != r_round) begin
              r_idx <= r_idx + N'(1);
              r_led <= btn_i;
            end else if (r_round == r_level) begin
              r_state <= ST_WIN;
              r_busy  <= 1'b0;
              r_win   <= 1'b1;
            end else begin
              r_round  <= r_round + N'(1);
              r_idx    <= '0;
              r_replay <= 1'b1;
              r_state  <= ST_SHOW_OFF;
            end
          end else begin
            r_state <= ST_LOSE;
            r_busy  <= 1'b0;
            r_lose  <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign led_o   = r_led;
  assign round_o = r_round;
  assign busy_o  = r_busy;
  assign win_o   = r_win;
  assign lose_o  = r_lose;

endmodule

// File: tb/tb_genius_round_ctrl.sv
// Directed self-checking bench for genius_round_ctrl with default timing parameters.
module tb_genius_round_ctrl;

  logic       clk_i;
  logic       rn_i;
  logic       start_i;
  logic [7:0] seed_i;
  logic [3:0] level_i;
  logic [3:0] btn_i;
  logic [3:0] led_o;
  logic [3:0] round_o;
  logic       busy_o;
  logic       win_o;
  logic       lose_o;

  int errors = 0;
  int checks = 0;
  logic [1:0] seq_m [16];

  genius_round_ctrl #(.N(4), .SHOW_T(8), .GAP_T(4), .TO_T(64)) dut (
    .clk_i   (clk_i),
    .rn_i    (rn_i),
    .start_i (start_i),
    .seed_i  (seed_i),
    .level_i (level_i),
    .btn_i   (btn_i),
    .led_o   (led_o),
    .round_o (round_o),
    .busy_o  (busy_o),
    .win_o   (win_o),
    .lose_o  (lose_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  task automatic build_seq(input logic [7:0] seed);
    logic [7:0] s;
    s = (seed == 8'h00) ? 8'h01 : seed;
    for (int k = 0; k < 16; k++) begin
      s = lfsr_step(s);
      seq_m[k] = s[1:0];
    end
  endtask

  // Starts a game and walks the 16 LOAD cycles; optionally injects start/btn noise at cycle inj
  task automatic start_game(input logic [7:0] seed, input logic [3:0] level, input int inj,
                            input string name);
    build_seq(seed);
    seed_i = seed; level_i = level; start_i = 1'b1;
    tick;
    start_i = 1'b0; seed_i = 8'h00; level_i = 4'd0;
    for (int c = 0; c < 16; c++) begin
      checks++;
      if ({led_o, busy_o, win_o, lose_o, round_o} !== {4'b0000, 1'b1, 1'b0, 1'b0, 4'd0}) begin
        errors++;
        $display("FAIL %s load c=%0d: got led=%b busy=%b win=%b lose=%b round=%0d, want led=0000 busy=1 win=0 lose=0 round=0",
                 name, c, led_o, busy_o, win_o, lose_o, round_o);
      end
      if (c == inj) begin
        start_i = 1'b1; seed_i = 8'hFF; level_i = 4'd9; btn_i = 4'b1111;
      end
      tick;
      start_i = 1'b0; seed_i = 8'h00; level_i = 4'd0; btn_i = 4'b0000;
    end
  endtask

  // From the first SHOW_ON cycle of round r to the first INPUT cycle
  task automatic show_round(input int r, input string name);
    for (int j = 0; j <= r; j++) begin
      for (int c = 0; c < 8; c++) begin
        checks++;
        if ({led_o, busy_o, round_o} !== {oh(seq_m[j]), 1'b1, 4'(r)}) begin
          errors++;
          $display("FAIL %s show r=%0d j=%0d c=%0d: got led=%b busy=%b round=%0d, want led=%b busy=1 round=%0d",
                   name, r, j, c, led_o, busy_o, round_o, oh(seq_m[j]), r);
        end
        tick;
      end
      for (int c = 0; c < 4; c++) begin
        checks++;
        if ({led_o, busy_o} !== {4'b0000, 1'b1}) begin
          errors++;
          $display("FAIL %s gap r=%0d j=%0d c=%0d: got led=%b busy=%b, want led=0000 busy=1",
                   name, r, j, c, led_o, busy_o);
        end
        tick;
      end
    end
  endtask

  // Presses round r correctly; ends at WIN or at the first SHOW_ON cycle of round r+1
  task automatic press_round(input int r, input int level, input string name);
    for (int j = 0; j <= r; j++) begin
      btn_i = oh(seq_m[j]);
      tick;
      btn_i = 4'b0000;
      if (j < r) begin
        checks++;
        if ({led_o, busy_o, win_o, lose_o} !== {oh(seq_m[j]), 1'b1, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL %s echo r=%0d j=%0d: got led=%b busy=%b win=%b lose=%b, want led=%b busy=1 win=0 lose=0",
                   name, r, j, led_o, busy_o, win_o, lose_o, oh(seq_m[j]));
        end
      end else if (r == level) begin
        checks++;
        if ({win_o, lose_o, busy_o, led_o, round_o} !== {1'b1, 1'b0, 1'b0, 4'b0000, 4'(level)}) begin
          errors++;
          $display("FAIL %s win: got win=%b lose=%b busy=%b led=%b round=%0d, want win=1 lose=0 busy=0 led=0000 round=%0d",
                   name, win_o, lose_o, busy_o, led_o, round_o, level);
        end
      end else begin
        for (int c = 0; c < 4; c++) begin
          checks++;
          if ({led_o, busy_o, round_o} !== {4'b0000, 1'b1, 4'(r + 1)}) begin
            errors++;
            $display("FAIL %s next-round gap r=%0d c=%0d: got led=%b busy=%b round=%0d, want led=0000 busy=1 round=%0d",
                     name, r, c, led_o, busy_o, round_o, r + 1);
          end
          tick;
        end
      end
    end
  endtask

  task automatic play_game(input logic [7:0] seed, input int level, input string name);
    start_game(seed, 4'(level), -1, name);
    for (int r = 0; r <= level; r++) begin
      show_round(r, name);
      press_round(r, level, name);
    end
  endtask

  task automatic check_lose(input logic [3:0] want_round, input string name);
    checks++;
    if ({lose_o, win_o, busy_o, led_o, round_o} !== {1'b1, 1'b0, 1'b0, 4'b0000, want_round}) begin
      errors++;
      $display("FAIL %s lose: got lose=%b win=%b busy=%b led=%b round=%0d, want lose=1 win=0 busy=0 led=0000 round=%0d",
               name, lose_o, win_o, busy_o, led_o, round_o, want_round);
    end
  endtask

  task automatic test_reset;
    rn_i = 1'b0; start_i = 1'b0; seed_i = 8'h00; level_i = 4'd0; btn_i = 4'b0000;
    tick; tick;
    checks++;
    if ({led_o, round_o, busy_o, win_o, lose_o} !== 11'd0) begin
      errors++;
      $display("FAIL reset: got led=%b round=%0d busy=%b win=%b lose=%b, want all 0",
               led_o, round_o, busy_o, win_o, lose_o);
    end
    @(negedge clk_i);
    rn_i = 1'b1;
    btn_i = 4'b0100;
    tick;
    btn_i = 4'b0000;
    tick;
    checks++;
    if ({led_o, round_o, busy_o, win_o, lose_o} !== 11'd0) begin
      errors++;
      $display("FAIL idle_btn: got led=%b round=%0d busy=%b win=%b lose=%b, want all 0",
               led_o, round_o, busy_o, win_o, lose_o);
    end
  endtask

  task automatic test_min_game;
    play_game(8'h00, 0, "min_game");
  endtask

  task automatic test_three_rounds;
    play_game(8'h5A, 2, "three_rounds");
  endtask

  task automatic test_wrong_colour;
    logic [1:0] bad;
    start_game(8'hC3, 4'd3, -1, "wrong_colour");
    show_round(0, "wrong_colour");
    press_round(0, 3, "wrong_colour");
    show_round(1, "wrong_colour");
    btn_i = oh(seq_m[0]);
    tick;
    btn_i = 4'b0000;
    checks++;
    if ({led_o, busy_o, lose_o} !== {oh(seq_m[0]), 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrong_colour first press: got led=%b busy=%b lose=%b, want led=%b busy=1 lose=0",
               led_o, busy_o, lose_o, oh(seq_m[0]));
    end
    bad = seq_m[1] + 2'd1;
    btn_i = oh(bad);
    tick;
    btn_i = 4'b0000;
    check_lose(4'd1, "wrong_colour");
  endtask

  task automatic test_timeout;
    start_game(8'h37, 4'd3, -1, "timeout");
    show_round(0, "timeout");
    for (int c = 0; c < 64; c++) begin
      checks++;
      if ({busy_o, lose_o} !== 2'b10) begin
        errors++;
        $display("FAIL timeout early c=%0d: got busy=%b lose=%b, want busy=1 lose=0", c, busy_o, lose_o);
      end
      tick;
    end
    check_lose(4'd0, "timeout");
  endtask

  task automatic test_multi_bit;
    start_game(8'h91, 4'd3, -1, "multi_bit");
    show_round(0, "multi_bit");
    btn_i = 4'b0011;
    tick;
    btn_i = 4'b0000;
    check_lose(4'd0, "multi_bit");
  endtask

  task automatic test_ignore_and_reset;
    start_game(8'h2B, 4'd1, 5, "ignore");
    checks++;
    if ({led_o, busy_o} !== {oh(seq_m[0]), 1'b1}) begin
      errors++;
      $display("FAIL ignore first show: got led=%b busy=%b, want led=%b busy=1", led_o, busy_o, oh(seq_m[0]));
    end
    start_i = 1'b1; seed_i = 8'hFF; btn_i = oh(seq_m[0]);
    tick;
    start_i = 1'b0; seed_i = 8'h00; btn_i = 4'b0000;
    checks++;
    if ({led_o, busy_o, round_o, win_o, lose_o} !== {oh(seq_m[0]), 1'b1, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ignore show: got led=%b busy=%b round=%0d win=%b lose=%b, want led=%b busy=1 round=0 win=0 lose=0",
               led_o, busy_o, round_o, win_o, lose_o, oh(seq_m[0]));
    end
    tick;
    #2;
    rn_i = 1'b0;
    #1;
    checks++;
    if ({led_o, round_o, busy_o, win_o, lose_o} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: got led=%b round=%0d busy=%b win=%b lose=%b, want all 0",
               led_o, round_o, busy_o, win_o, lose_o);
    end
    @(negedge clk_i);
    rn_i = 1'b1;
    tick;
    play_game(8'h6E, 1, "after_reset");
  endtask

  initial begin
    test_reset;
    test_min_game;
    test_three_rounds;
    test_wrong_colour;
    test_timeout;
    test_multi_bit;
    test_ignore_and_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
